scan_frame_capture: RTL and testbench

SCAN_FRAME_CAPTURE -- requirements
Module: scan_frame_capture

---
 rtl/scan_frame_capture.sv | 111 +++++++++++
 tb/tb_scan_frame_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_frame_capture.sv
// scan_frame_capture: debounces a multiplexed 8-digit BCD scan and captures
// each complete left-to-right pass as one 32-bit frame with a dp mask.
module scan_frame_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  digit,
    input  logic [3:0]  bcd,
    input  logic        dp,
    input  logic        frame_ack,
    output logic [31:0] frame,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t      state_q, state_d;
    logic [7:0]  dig_q;
    logic [3:0]  bcd_q;
    logic        dp_q;
    logic [3:0]  stab_q;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] sh_q, sh_d, frame_q, frame_d;
    logic [7:0]  shdp_q, shdp_d, mask_q, mask_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic        chg, acc, bad, start, next, done;

    // acc fires on the edge where the stability count reaches STABLE_CYCLES;
    // blank (all-zero) digits never count as an accept.
    assign chg   = {digit, bcd, dp} != {dig_q, bcd_q, dp_q};
    assign acc   = !chg && stab_q == 4'(STABLE_CYCLES - 1) && dig_q != 8'h00;
    assign bad   = bcd_q > 4'd9;
    assign start = acc && dig_q == 8'h80 && !bad && state_q != HOLD;
    assign next  = acc && state_q == COLLECT && dig_q == exp_q && !bad;
    assign done  = next && exp_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q  <= 8'h00;
            bcd_q  <= 4'h0;
            dp_q   <= 1'b0;
            stab_q <= 4'h0;
        end else if (chg) begin
            {dig_q, bcd_q, dp_q} <= {digit, bcd, dp};
            stab_q <= 4'd1;
        end else if (stab_q != 4'hF) begin
            stab_q <= stab_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            exp_q   <= 8'h00;
            sh_q    <= 32'h0;
            shdp_q  <= 8'h00;
            frame_q <= 32'h0;
            mask_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            sh_q    <= sh_d;
            shdp_q  <= shdp_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: state_d = done ? HOLD : (start || next) ? COLLECT : acc ? IDLE : COLLECT;
            HOLD:    if (frame_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An out-of-order leftmost digit both flags an error and restarts the frame.
    always_comb begin
        err_d  = acc && ((state_q == IDLE && dig_q == 8'h80 && bad) || (state_q == COLLECT && !next));
        exp_d  = start ? 8'h40 : next ? exp_q >> 1 : exp_q;
        sh_d   = sh_q;
        shdp_d = shdp_q;
        for (int i = 0; i < 8; i++) begin
            if ((start || next) && dig_q[i]) begin
                sh_d[4*i +: 4] = bcd_q;
                shdp_d[i]      = dp_q;
            end
        end
        frame_d = done ? sh_d : frame_q;
        mask_d  = done ? shdp_d : mask_q;
        valid_d = done || (valid_q && !frame_ack);
        cnt_d   = cnt_q + 8'(err_d && cnt_q != 8'hFF);
    end

    assign frame       = frame_q;
    assign dp_mask     = mask_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_cnt     = cnt_q;
endmodule

// File: tb/tb_scan_frame_capture.sv
// tb_scan_frame_capture: directed scans with hand-computed frames, errors
// and counter values for scan_frame_capture.
module tb_scan_frame_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  digit;
    logic [3:0]  bcd;
    logic        dp;
    logic        frame_ack;
    logic [31:0] frame;
    logic [7:0]  dp_mask;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;
    int          checks = 0;
    int          errs = 0;
    int          npulse = 0;
    int          n0;

    scan_frame_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .digit(digit), .bcd(bcd), .dp(dp),
        .frame_ack(frame_ack), .frame(frame), .dp_mask(dp_mask),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Counts cycles with frame_err high, so a stuck pulse shows as extra counts.
    always @(negedge clk) if (frame_err === 1'b1) npulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic [3:0] b, input logic p, input int n);
        digit = d;
        bcd   = b;
        dp    = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] f, input logic [7:0] m, input int n);
        for (int i = 7; i >= 0; i--) put(8'(1 << i), f[4*i +: 4], m[i], n);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        digit = 8'h00;
        bcd = 4'h0;
        dp = 1'b0;
        frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_frame", frame, 32'h0);
        chk("rst_mask", {24'h0, dp_mask}, 32'h0);
        chk("rst_valid", {31'h0, frame_valid}, 32'h0);
        chk("rst_err", {31'h0, frame_err}, 32'h0);
        chk("rst_cnt", {24'h0, err_cnt}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // clean scan, held while unacknowledged
        scan(32'h0134_5927, 8'h55, 10);
        chk("clean_frame", frame, 32'h0134_5927);
        chk("clean_mask", {24'h0, dp_mask}, 32'h55);
        chk("clean_valid", {31'h0, frame_valid}, 32'h1);
        put(8'h01, 4'd7, 1'b1, 20);
        chk("clean_hold_valid", {31'h0, frame_valid}, 32'h1);
        chk("clean_no_err", npulse, 0);
        ack();
        chk("ack_clears", {31'h0, frame_valid}, 32'h0);
        ack();
        chk("idle_ack_valid", {31'h0, frame_valid}, 32'h0);
        chk("idle_ack_frame", frame, 32'h0134_5927);

        // second scan while holding is ignored
        scan(32'h2468_1357, 8'hA0, 6);
        chk("a_frame", frame, 32'h2468_1357);
        scan(32'h9876_5432, 8'h0F, 6);
        chk("hold_frame", frame, 32'h2468_1357);
        chk("hold_mask", {24'h0, dp_mask}, 32'hA0);
        chk("hold_valid", {31'h0, frame_valid}, 32'h1);
        chk("hold_no_err", npulse, 0);
        ack();
        chk("hold_ack", {31'h0, frame_valid}, 32'h0);
        scan(32'h9876_5432, 8'h0F, 6);
        chk("b_frame", frame, 32'h9876_5432);
        chk("b_mask", {24'h0, dp_mask}, 32'h0F);
        ack();

        // digit 08 too short, so 04 arrives out of order
        n0 = npulse;
        put(8'h80, 4'd0, 1'b0, 10);
        put(8'h40, 4'd1, 1'b1, 10);
        put(8'h20, 4'd3, 1'b0, 10);
        put(8'h10, 4'd4, 1'b1, 10);
        put(8'h08, 4'd5, 1'b0, 3);
        put(8'h04, 4'd9, 1'b1, 10);
        put(8'h02, 4'd2, 1'b0, 10);
        put(8'h01, 4'd7, 1'b1, 10);
        chk("short_pulses", npulse - n0, 1);
        chk("short_cnt", {24'h0, err_cnt}, 32'h1);
        chk("short_valid", {31'h0, frame_valid}, 32'h0);
        chk("short_frame", frame, 32'h9876_5432);

        // non-one-hot digit, then bcd>9 in the expected slot
        n0 = npulse;
        put(8'h80, 4'd2, 1'b0, 6);
        put(8'h30, 4'd3, 1'b0, 6);
        for (int i = 5; i >= 0; i--) put(8'(1 << i), 4'd1, 1'b0, 6);
        chk("onehot_pulses", npulse - n0, 1);
        chk("onehot_cnt", {24'h0, err_cnt}, 32'h2);
        put(8'h80, 4'd1, 1'b0, 6);
        put(8'h40, 4'hC, 1'b0, 6);
        put(8'h20, 4'd3, 1'b0, 6);
        chk("badbcd_pulses", npulse - n0, 2);
        chk("badbcd_cnt", {24'h0, err_cnt}, 32'h3);
        chk("badbcd_valid", {31'h0, frame_valid}, 32'h0);

        // restart on out-of-order leftmost digit, blanking gaps between digits
        n0 = npulse;
        put(8'h00, 4'd0, 1'b0, 6);
        put(8'h80, 4'd9, 1'b0, 6);
        put(8'h00, 4'd0, 1'b0, 6);
        put(8'h40, 4'd8, 1'b0, 6);
        put(8'h00, 4'd0, 1'b0, 6);
        put(8'h80, 4'd1, 1'b1, 6);
        for (int i = 6; i >= 0; i--) begin
            put(8'h00, 4'd0, 1'b0, 6);
            put(8'(1 << i), 4'(8 - i), 1'b0, 6);
        end
        chk("restart_pulses", npulse - n0, 1);
        chk("restart_cnt", {24'h0, err_cnt}, 32'h4);
        chk("restart_frame", frame, 32'h1234_5678);
        chk("restart_mask", {24'h0, dp_mask}, 32'h80);
        chk("restart_valid", {31'h0, frame_valid}, 32'h1);
        ack();

        // asynchronous reset mid-collect
        put(8'h80, 4'd5, 1'b0, 10);
        put(8'h40, 4'd6, 1'b0, 10);
        put(8'h20, 4'd7, 1'b0, 10);
        put(8'h10, 4'd8, 1'b1, 10);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_frame", frame, 32'h0);
        chk("mid_rst_mask", {24'h0, dp_mask}, 32'h0);
        chk("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
        chk("mid_rst_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        n0 = npulse;
        put(8'h08, 4'd9, 1'b0, 10);
        put(8'h04, 4'd1, 1'b0, 10);
        put(8'h02, 4'd2, 1'b0, 10);
        put(8'h01, 4'd3, 1'b0, 10);
        chk("post_rst_valid", {31'h0, frame_valid}, 32'h0);
        chk("post_rst_pulses", npulse - n0, 0);
        scan(32'h5050_9090, 8'h3C, 6);
        chk("post_rst_frame", frame, 32'h5050_9090);
        chk("post_rst_mask", {24'h0, dp_mask}, 32'h3C);
        chk("post_rst_fvalid", {31'h0, frame_valid}, 32'h1);
        ack();

        // error counter saturation
        n0 = npulse;
        for (int k = 1; k <= 300; k++) begin
            put(8'h80, (k % 2) ? 4'hA : 4'hB, 1'b0, 5);
            if (k == 254) chk("sat_254", {24'h0, err_cnt}, 32'hFE);
            if (k == 255) chk("sat_255", {24'h0, err_cnt}, 32'hFF);
        end
        chk("sat_300", {24'h0, err_cnt}, 32'hFF);
        chk("sat_pulses", npulse - n0, 300);
        chk("sat_valid", {31'h0, frame_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
